// File: rtl/bsg_fifo_1r1w_sf_packet_writer.sv
// bsg_fifo_1r1w_sf_packet_writer
//
// Producer-side front end for a 1r1w store-and-forward FIFO. Every beat of
// an incoming packet is written into the FIFO's speculative region as it
// arrives. Each packet is validated by an additive checksum carried in its
// final beat, by upstream error flags, and by a length limit. Exactly one
// commit pulse follows each packet, qualified with a drop flag, so only
// good packets ever become visible at the FIFO read port.
//
// Ports:
//   clk_i               clock
//   reset_n_i           synchronous active-low reset
//   data_i/v_i          upstream beat and valid
//   last_i              beat is the final (checksum) beat of the packet
//   err_i               beat is marked corrupt by upstream
//   ready_o             upstream ready; a beat transfers on v_i & ready_o
//   fifo_data_o/fifo_v_o  FIFO write data and valid
//   fifo_ready_i        FIFO write ready
//   fifo_commit_v_o     one-cycle commit pulse
//   fifo_commit_drop_o  commit qualifier, 1 = discard the speculative packet
//   ok_count_o          saturating count of committed good packets
//   drop_count_o        saturating count of dropped packets

module bsg_fifo_1r1w_sf_packet_writer #(
    parameter int width_p     = 8,
    parameter int max_beats_p = 4,
    parameter int cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   v_i,
    input  logic                   last_i,
    input  logic                   err_i,
    output logic                   ready_o,
    output logic [width_p-1:0]     fifo_data_o,
    output logic                   fifo_v_o,
    input  logic                   fifo_ready_i,
    output logic                   fifo_commit_v_o,
    output logic                   fifo_commit_drop_o,
    output logic [cnt_width_p-1:0] ok_count_o,
    output logic [cnt_width_p-1:0] drop_count_o
);

    localparam int CountWidth = $clog2(max_beats_p + 1);

    typedef enum logic [1:0] {
        RECV,
        COMMIT,
        DISCARD
    } state_t;

    state_t                  r_state;
    state_t                  r_nextState;
    state_t                  w_stateNext;
    logic [CountWidth-1:0]   r_count;
    logic [width_p-1:0]      r_sum;
    logic                    r_bad;
    logic                    r_drop;
    logic [cnt_width_p-1:0]  r_okCount;
    logic [cnt_width_p-1:0]  r_dropCount;

    logic                    w_accept;
    logic [CountWidth-1:0]   w_countInc;
    logic                    w_overlong;

    // The data path is a straight wire; only the handshake is gated by state.
    assign fifo_data_o  = data_i;
    assign ok_count_o   = r_okCount;
    assign drop_count_o = r_dropCount;

    assign w_accept   = (r_state == RECV) && v_i && fifo_ready_i;
    assign w_countInc = r_count + 1'b1;
    assign w_overlong = (w_countInc == CountWidth'(max_beats_p));

    // Next-state and handshake outputs. The checksum beat and the
    // max_beats_p-th non-last beat both lead to a single COMMIT cycle.
    always_comb begin
        w_stateNext        = r_state;
        ready_o            = 1'b0;
        fifo_v_o           = 1'b0;
        fifo_commit_v_o    = 1'b0;
        fifo_commit_drop_o = 1'b0;
        case (r_state)
            RECV: begin
                ready_o  = fifo_ready_i;
                fifo_v_o = v_i;
                if (w_accept && (last_i || w_overlong)) begin
                    w_stateNext = COMMIT;
                end
            end
            COMMIT: begin
                fifo_commit_v_o    = 1'b1;
                fifo_commit_drop_o = r_drop;
                w_stateNext        = r_nextState;
            end
            DISCARD: begin
                // Tail of an overlong packet is swallowed without FIFO writes.
                ready_o = 1'b1;
                if (v_i && last_i) begin
                    w_stateNext = RECV;
                end
            end
            default: begin
                w_stateNext = RECV;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= RECV;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Packet bookkeeping: running sum, beat count, bad/drop flags and the
    // state to resume after the commit cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_count     <= '0;
            r_sum       <= '0;
            r_bad       <= 1'b0;
            r_drop      <= 1'b0;
            r_nextState <= RECV;
        end else if (w_accept) begin
            if (last_i) begin
                // The checksum beat is compared, never accumulated.
                r_drop      <= r_bad | err_i | (data_i != r_sum);
                r_nextState <= RECV;
            end else begin
                r_sum   <= r_sum + data_i;
                r_count <= w_countInc;
                r_bad   <= r_bad | err_i;
                if (w_overlong) begin
                    r_drop      <= 1'b1;
                    r_nextState <= DISCARD;
                end
            end
        end else if (r_state == COMMIT) begin
            r_count <= '0;
            r_sum   <= '0;
            r_bad   <= 1'b0;
        end
    end

    // Saturating statistics, bumped at the edge that closes the commit cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_okCount   <= '0;
            r_dropCount <= '0;
        end else if (r_state == COMMIT) begin
            if (r_drop) begin
                if (r_dropCount != {cnt_width_p{1'b1}}) begin
                    r_dropCount <= r_dropCount + 1'b1;
                end
            end else begin
                if (r_okCount != {cnt_width_p{1'b1}}) begin
                    r_okCount <= r_okCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_fifo_1r1w_sf_packet_writer.sv
// Self-checking bench for bsg_fifo_1r1w_sf_packet_writer with width 8,
// four beats per packet at most and 2-bit statistics counters so that
// saturation is reached quickly. Packets are described as beat arrays and
// the expected outcome is computed from the packet contents alone.

module tb_bsg_fifo_1r1w_sf_packet_writer;

    localparam int W    = 8;
    localparam int MAXB = 4;
    localparam int CNTW = 2;
    localparam int CMAX = 3;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [W-1:0]    data_i;
    logic            v_i;
    logic            last_i;
    logic            err_i;
    logic            ready_o;
    logic [W-1:0]    fifo_data_o;
    logic            fifo_v_o;
    logic            fifo_ready_i;
    logic            fifo_commit_v_o;
    logic            fifo_commit_drop_o;
    logic [CNTW-1:0] ok_count_o;
    logic [CNTW-1:0] drop_count_o;

    int passCount  = 0;
    int checkCount = 0;
    int failCount  = 0;
    int expOk      = 0;
    int expDropCnt = 0;
    int dutWrites  = 0;
    int dutCommits = 0;

    logic [W-1:0] pktData [16];
    logic         pktErr  [16];
    int           pktLen;

    always #5 clk_i = ~clk_i;

    bsg_fifo_1r1w_sf_packet_writer #(
        .width_p     (W),
        .max_beats_p (MAXB),
        .cnt_width_p (CNTW)
    ) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .data_i             (data_i),
        .v_i                (v_i),
        .last_i             (last_i),
        .err_i              (err_i),
        .ready_o            (ready_o),
        .fifo_data_o        (fifo_data_o),
        .fifo_v_o           (fifo_v_o),
        .fifo_ready_i       (fifo_ready_i),
        .fifo_commit_v_o    (fifo_commit_v_o),
        .fifo_commit_drop_o (fifo_commit_drop_o),
        .ok_count_o         (ok_count_o),
        .drop_count_o       (drop_count_o)
    );

    // One comparison point: count it, and report a mismatch with its tag.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Tally what the DUT does in the current (settled) cycle.
    task automatic sampleActivity();
        if (fifo_v_o === 1'b1 && fifo_ready_i === 1'b1) dutWrites++;
        if (fifo_commit_v_o === 1'b1) dutCommits++;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_ok_count"}, 32'(ok_count_o), 32'(expOk));
        checkOutput({tag, "_drop_count"}, 32'(drop_count_o), 32'(expDropCnt));
    endtask

    // Outcome of a packet from its contents: overlong packets write MAXB
    // beats and drop; otherwise all beats are written and the packet is
    // good only if no beat is flagged and the last beat equals the mod-256
    // sum of the others.
    function automatic void modelPacket(output int writes, output bit drop);
        logic [W-1:0] s;
        bit           e;
        s = '0;
        e = 1'b0;
        if (pktLen > MAXB) begin
            writes = MAXB;
            drop   = 1'b1;
        end else begin
            for (int i = 0; i < pktLen - 1; i++) s = s + pktData[i];
            for (int i = 0; i < pktLen; i++) e = e | pktErr[i];
            writes = pktLen;
            drop   = e || (pktData[pktLen-1] != s);
        end
    endfunction

    task automatic load3(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic errMid);
        pktLen     = 3;
        pktData[0] = a; pktData[1] = b; pktData[2] = c;
        pktErr[0]  = 1'b0; pktErr[1] = errMid; pktErr[2] = 1'b0;
    endtask

    task automatic load1(input logic [W-1:0] a);
        pktLen     = 1;
        pktData[0] = a;
        pktErr[0]  = 1'b0;
    endtask

    // Commit cycle: expect the pulse with the model's drop, handshake closed.
    task automatic expectCommit(input bit expDrop);
        @(negedge clk_i);
        v_i          = 1'($urandom_range(0, 1));
        data_i       = W'($urandom);
        last_i       = 1'b0;
        err_i        = 1'b0;
        fifo_ready_i = 1'($urandom_range(0, 1));
        #1;
        sampleActivity();
        checkOutput("commit_v", 32'(fifo_commit_v_o), 32'd1);
        checkOutput("commit_drop", 32'(fifo_commit_drop_o), 32'(expDrop));
        checkOutput("commit_ready", 32'(ready_o), 32'd0);
        checkOutput("commit_fifo_v", 32'(fifo_v_o), 32'd0);
        checkCounters("commit");
        if (expDrop) begin
            if (expDropCnt < CMAX) expDropCnt++;
        end else begin
            if (expOk < CMAX) expOk++;
        end
    endtask

    // Drive the loaded packet. readyMode: 0 always ready, 1 toggling, 2 random.
    task automatic applyStimulus(input int readyMode);
        int  writes;
        bit  expDrop;
        int  idx;
        int  accepted;
        int  cycles;
        bit  discarding;
        bit  toggle;
        bit  rdy;
        modelPacket(writes, expDrop);
        idx        = 0;
        accepted   = 0;
        cycles     = 0;
        discarding = 1'b0;
        toggle     = 1'b1;
        dutWrites  = 0;
        dutCommits = 0;
        while (idx < pktLen) begin
            @(negedge clk_i);
            cycles++;
            if (cycles > 200) begin
                checkOutput("packet_timeout", 32'(idx), 32'(pktLen));
                break;
            end
            case (readyMode)
                0:       rdy = 1'b1;
                1:       rdy = toggle;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            toggle       = ~toggle;
            fifo_ready_i = rdy;
            v_i          = 1'b1;
            data_i       = pktData[idx];
            last_i       = (idx == pktLen - 1);
            err_i        = pktErr[idx];
            #1;
            sampleActivity();
            checkOutput("beat_commit_v", 32'(fifo_commit_v_o), 32'd0);
            checkOutput("beat_commit_drop", 32'(fifo_commit_drop_o), 32'd0);
            checkCounters("beat");
            if (!discarding) begin
                checkOutput("recv_ready", 32'(ready_o), 32'(rdy));
                checkOutput("recv_fifo_v", 32'(fifo_v_o), 32'd1);
                checkOutput("recv_data", 32'(fifo_data_o), 32'(pktData[idx]));
                if (rdy) begin
                    idx++;
                    accepted++;
                    if (idx == pktLen || accepted == MAXB) begin
                        expectCommit(expDrop);
                        discarding = (idx < pktLen);
                    end
                end
            end else begin
                checkOutput("discard_ready", 32'(ready_o), 32'd1);
                checkOutput("discard_fifo_v", 32'(fifo_v_o), 32'd0);
                idx++;
            end
        end
        // Idle cycle back in the receive state with the counters settled.
        @(negedge clk_i);
        v_i          = 1'b0;
        last_i       = 1'b0;
        err_i        = 1'b0;
        fifo_ready_i = 1'($urandom_range(0, 1));
        #1;
        checkOutput("idle_ready", 32'(ready_o), 32'(fifo_ready_i));
        checkOutput("idle_fifo_v", 32'(fifo_v_o), 32'd0);
        checkOutput("idle_commit_v", 32'(fifo_commit_v_o), 32'd0);
        checkCounters("idle");
        checkOutput("packet_writes", 32'(dutWrites), 32'(writes));
        checkOutput("packet_commits", 32'(dutCommits), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_commit_v"}, 32'(fifo_commit_v_o), 32'd0);
        checkOutput({tag, "_commit_drop"}, 32'(fifo_commit_drop_o), 32'd0);
        checkOutput({tag, "_ready"}, 32'(ready_o), 32'(fifo_ready_i));
        checkOutput({tag, "_fifo_v"}, 32'(fifo_v_o), 32'(v_i));
        checkCounters(tag);
    endtask

    initial begin
        reset_n_i    = 1'b0;
        v_i          = 1'b0;
        data_i       = '0;
        last_i       = 1'b0;
        err_i        = 1'b0;
        fifo_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_n_i    = 1'b1;
        fifo_ready_i = 1'b1;
        v_i          = 1'b1;
        #1;
        checkResetState("reset");
        v_i = 1'b0;

        $display("[TB] good packet");
        load3(8'h10, 8'h20, 8'h30, 1'b0);
        applyStimulus(0);

        $display("[TB] checksum wrap-around");
        load3(8'hFF, 8'h02, 8'h00, 1'b0);
        applyStimulus(0);
        load3(8'hFF, 8'h02, 8'h01, 1'b0);
        applyStimulus(0);

        $display("[TB] error flag on middle beat");
        load3(8'h05, 8'h06, 8'h0B, 1'b1);
        applyStimulus(0);
        load3(8'h05, 8'h06, 8'h0B, 1'b0);
        applyStimulus(0);

        $display("[TB] overlong packet");
        pktLen = 6;
        for (int i = 0; i < 6; i++) begin
            pktData[i] = W'(8'h21 + i);
            pktErr[i]  = 1'b0;
        end
        applyStimulus(0);
        load3(8'h01, 8'h02, 8'h03, 1'b0);
        applyStimulus(0);

        $display("[TB] exact-length packet");
        pktLen = 4;
        pktData[0] = 8'h40; pktData[1] = 8'h41; pktData[2] = 8'h42; pktData[3] = 8'hC3;
        for (int i = 0; i < 4; i++) pktErr[i] = 1'b0;
        applyStimulus(2);

        $display("[TB] toggling backpressure");
        load3(8'h11, 8'h22, 8'h33, 1'b0);
        applyStimulus(1);

        $display("[TB] randomized packets");
        for (int p = 0; p < 40; p++) begin
            logic [W-1:0] s;
            pktLen = $urandom_range(1, 6);
            s      = '0;
            for (int i = 0; i < pktLen; i++) begin
                pktData[i] = W'($urandom);
                pktErr[i]  = ($urandom_range(0, 7) == 0);
                if (i < pktLen - 1) s = s + pktData[i];
            end
            if ($urandom_range(0, 1) == 1) pktData[pktLen-1] = s;
            applyStimulus(2);
        end

        $display("[TB] reset mid-packet");
        dutCommits = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            v_i          = 1'b1;
            fifo_ready_i = 1'b1;
            data_i       = W'(8'h50 + i);
            last_i       = 1'b0;
            err_i        = 1'b0;
            #1;
            sampleActivity();
        end
        @(negedge clk_i);
        v_i       = 1'b0;
        reset_n_i = 1'b0;
        #1;
        sampleActivity();
        @(negedge clk_i);
        reset_n_i  = 1'b1;
        expOk      = 0;
        expDropCnt = 0;
        #1;
        sampleActivity();
        checkResetState("midreset");
        checkOutput("midreset_no_commit", 32'(dutCommits), 32'd0);

        load1(8'h00);
        applyStimulus(0);
        load1(8'h05);
        applyStimulus(0);

        $display("[TB] counter saturation");
        for (int p = 0; p < 5; p++) begin
            load1(8'h00);
            applyStimulus(2);
        end
        checkOutput("saturated_ok_count", 32'(ok_count_o), 32'(CMAX));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/bsg_fifo_1r1w_sf_packet_writer.md
# bsg_fifo_1r1w_sf_packet_writer

Producer-side front end for the 1r1w store-and-forward FIFO. It takes a beat stream with last and error flags, writes every beat into the FIFO's speculative region, and validates each packet with an additive checksum and a length limit. After each packet it issues exactly one commit or drop, so only good packets become visible at the FIFO read port. It sits between a link receiver or serializer and the FIFO write/commit ports.

## Interface
- width_p, none (required), beat width; the checksum is computed at this width.
- max_beats_p, none (required, ≥2), maximum beats per packet including the last (checksum) beat. Must be ≤ FIFO depth.
- cnt_width_p, 16, width of the saturating statistics counters.

- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- data_i  in  width_p  upstream beat
- v_i  in  1  upstream valid
- last_i  in  1  beat is the final (checksum) beat of the packet
- err_i  in  1  beat is marked corrupt by upstream
- ready_o  out  1  upstream ready; a beat transfers when v_i & ready_o
- fifo_data_o  out  width_p  FIFO write data (equals data_i)
- fifo_v_o  out  1  FIFO write valid
- fifo_ready_i  in  1  FIFO write ready; never depends on fifo_v_o
- fifo_commit_v_o  out  1  one-cycle commit pulse
- fifo_commit_drop_o  out  1  qualifies the commit: 1 = discard the speculative packet
- ok_count_o  out  cnt_width_p  number of committed good packets, saturating
- drop_count_o  out  cnt_width_p  number of dropped packets, saturating

## Operation
- State machine has three states: RECV, COMMIT, DISCARD. Registered state: beat count (clog2(max_beats_p+1) bits), running sum (width_p), bad flag, drop flag, and the next state after COMMIT.
- RECV:
  - ready_o = fifo_ready_i; fifo_v_o = v_i; fifo_data_o = data_i.
  - An accepted beat is one where v_i & fifo_ready_i.
  - Accepted beat with last_i=0:
    - sum += data_i, modulo 2^width_p.
    - count += 1.
    - bad |= err_i.
    - If the new count == max_beats_p (overlong packet): drop ← 1, go to COMMIT, then DISCARD.
  - Accepted beat with last_i=1:
    - drop ← bad | err_i | (data_i != sum).
    - Go to COMMIT, then RECV.
  - The checksum beat itself is written to the FIFO and is not added to sum.
- COMMIT: ready_o=0, fifo_v_o=0, fifo_commit_v_o=1, fifo_commit_drop_o=drop.
  - Clear sum, count and bad.
  - Increment ok_count_o if drop=0, otherwise drop_count_o.
  - Go to the stored next state.
- DISCARD: ready_o=1, fifo_v_o=0.
  - Swallow beats until an accepted beat with last_i=1 (v_i & ready_o), then go to RECV.
  - No second commit is issued; counters do not change.
- A single-beat packet (last_i on the first beat) is good only if data_i==0 and err_i==0.
- fifo_commit_v_o is 0 outside COMMIT. fifo_commit_drop_o is 0 whenever fifo_commit_v_o=0.
- Counters hold at 2^cnt_width_p−1 and do not wrap.

## Timing
- Reset (reset_n_i=0 at a clock edge):
  - state=RECV; sum, count, bad and drop cleared; both counters 0.
  - fifo_commit_v_o=0. fifo_v_o follows v_i and ready_o follows fifo_ready_i from the first cycle after reset.
- Reset mid-packet abandons the partial packet with no commit. Clearing the FIFO's speculative data is the FIFO's own reset responsibility.
- Data path has zero latency: fifo_data_o, fifo_v_o and ready_o are combinational from the inputs in RECV.
- The commit pulse occurs in the cycle after the last (or max_beats_p-th) beat is accepted. This gives exactly one bubble cycle per packet. Back-to-back packets sustain N/(N+1) throughput.
- The FIFO observes the commit strictly after the final beat's write.
- Counters update at the clock edge that ends the COMMIT cycle.
- fifo_ready_i low stalls RECV indefinitely; sum and count hold.

## Test plan
- Good packet (width_p=8): beats 0x10, 0x20, then last=0x30 -> 3 FIFO writes; cycle after last: commit_v=1, drop=0; ok_count_o=1.
- Bad checksum: 0xFF, 0x02, last=0x00 (correct value 0x01) -> commit_v=1, drop=1; drop_count_o=1. Then 0xFF, 0x02, last=0x01 -> drop=0, confirming the wrap-around sum is correct.
- err_i on the middle beat of an otherwise correct packet -> drop=1. The next packet commits with drop=0, proving bad is cleared.
- Overlong (max_beats_p=4): 6-beat packet -> 4 FIFO writes; commit with drop=1 the cycle after the 4th write; beats 5–6 consumed with fifo_v_o=0; no further commit. The next good packet is committed normally.
- Backpressure: toggle fifo_ready_i every cycle during a 3-beat good packet -> ready_o mirrors it; exactly 3 writes; exactly one commit with drop=0.
- Reset mid-packet, then single-beat packets 0x00 and 0x05 -> no commit for the partial packet; 0x00 gives drop=0; 0x05 gives drop=1. Counter saturation is checked with cnt_width_p=2 (5 good packets -> ok_count_o=3).
